// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd scheduler slice.
//   state_t   : scheduler FSM states
//   W_DEF     : default operand/result width, matches the gcd core
//   TIMER_W   : width of the WAIT-state watchdog counter
//   id_width(): number of bits needed to encode a requester index
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int W_DEF   = 8;
  localparam int TIMER_W = 16;

  // A single requester still needs a 1-bit index so ports never collapse to zero width.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin pick over N_REQ request lines.
//   valid : per-requester request bits
//   ptr   : requester with the highest priority this round
//   grant : one-hot winner (all zero when nothing is requested)
//   index : encoded winner
//   any   : at least one request is present
module gcd_rr_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index,
  output logic             any
);

  // Walk upward from ptr, wrapping at N_REQ; the first set bit wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!any && valid[(int'(ptr) + off) % N_REQ]) begin
        any   = 1'b1;
        index = IW'((int'(ptr) + off) % N_REQ);
        grant[(int'(ptr) + off) % N_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Shares one gcd core between N_REQ requesters: round-robin accept, start/done
// handshake with the core, tagged response, and a watchdog on the core.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid/req_a/req_b     : per-requester request and packed operands
//   req_ready                 : one-hot accept pulse (IDLE only)
//   rsp_valid/rsp_ready       : response handshake
//   rsp_id/rsp_y              : owning requester and gcd result
//   rsp_error/rsp_timeout     : error flag, and whether the watchdog caused it
//   busy                      : scheduler not in IDLE
//   core_start/core_a/core_b  : job launch towards the core
//   core_y/core_done/core_error : core completion
//
// state | meaning
// IDLE  | waiting for any request; winner accepted and latched this cycle
// ISSUE | one-cycle core_start pulse, watchdog cleared
// WAIT  | core running; watchdog counting
// RESP  | response held until rsp_ready
module gcd_sched
  import gcd_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int W       = W_DEF,
  parameter  int TIMEOUT = 255,
  localparam int IW      = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0] req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IW-1:0]    rsp_id,
  output logic [W-1:0]     rsp_y,
  output logic             rsp_error,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             core_start,
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_b,
  input  logic [W-1:0]     core_y,
  input  logic             core_done,
  input  logic             core_error
);

  state_t             state, state_n;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      id_q;
  logic [W-1:0]       a_q, b_q, y_q;
  logic               err_q, to_q;
  logic [TIMER_W-1:0] timer;

  logic [N_REQ-1:0]   grant;
  logic [IW-1:0]      gnt_idx;
  logic               any_req;
  logic               timer_last;

  gcd_rr_arbiter #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_arb (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .index(gnt_idx),
    .any  (any_req)
  );

  // Timer is 0 in the first WAIT cycle, so the TIMEOUT-th WAIT cycle sees TIMEOUT-1.
  assign timer_last = (timer == TIMER_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_ready  = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = grant;
        if (any_req) state_n = ISSUE;
      end
      ISSUE: begin
        core_start = 1'b1;
        state_n    = WAIT;
      end
      WAIT: begin
        // core_done takes precedence over an expiring watchdog
        if (core_done || timer_last) state_n = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            id_q <= gnt_idx;
            a_q  <= req_a[int'(gnt_idx)*W +: W];
            b_q  <= req_b[int'(gnt_idx)*W +: W];
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + TIMER_W'(1);
          if (core_done) begin
            y_q   <= core_y;
            err_q <= core_error;
            to_q  <= 1'b0;
          end else if (timer_last) begin
            y_q   <= '0;
            err_q <= 1'b1;
            to_q  <= 1'b1;
          end
        end
        RESP: begin
          // requester just served drops to lowest priority
          if (rsp_ready) rr_ptr <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_id      = id_q;
  assign rsp_y       = y_q;
  assign rsp_error   = err_q;
  assign rsp_timeout = to_q;
  assign core_a      = a_q;
  assign core_b      = b_q;

endmodule

// File: tb/tb_gcd_sched.sv
module tb_gcd_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 20;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_y;
  logic           rsp_error, rsp_timeout, busy, core_start;
  logic [W-1:0]   core_a, core_b;
  logic [W-1:0]   core_y = '0;
  logic           core_done = 1'b0;
  logic           core_error = 1'b0;

  always #5 clk = ~clk;

  gcd_sched #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_y(core_y), .core_done(core_done), .core_error(core_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requesters
  logic [N-1:0] vq = '0;
  logic [W-1:0] aq [N];
  logic [W-1:0] bq [N];
  logic [N-1:0] acc_mask = '0;
  bit rand_en = 0, spur_en = 0, rearm_en = 0;
  int rdy_mode = 1;
  int force_k = 3;

  // behavioural model of the current job
  bit m_active = 0;
  int m_ptr = 0, m_acc = 0, m_id = 0, m_rsp_start = 0, m_k = 1;
  logic [W-1:0] m_a, m_b, m_y;
  bit m_err, m_to;

  // core stub
  int done_at = -1;
  logic [W-1:0] st_a = '0, st_b = '0;

  // observation records
  int rsp_cnt = 0, start_cnt = 0, acc_cnt = 0, last_start = 0, first_valid = -1;
  int r_id[1024], r_y[1024], r_err[1024], r_to[1024], r_first[1024], r_start[1024], r_hs[1024];
  int a_id[1024], a_cyc[1024];

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return W'(x);
  endfunction

  function automatic logic [W-1:0] core_y_of(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a == 0 || b == 0) ? W'(8'hEE) : gcd_ref(a, b);
  endfunction

  // winner = requesting index closest upward (with wrap) from ptr
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int best, bd, d;
    best = -1; bd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - ptr + N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  function automatic int rand_k();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 1 + $urandom_range(0, 5);
    else if (r == 7) return TO - 1;
    else if (r == 8) return TO;
    else             return TO + 1 + $urandom_range(0, 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // compare process: DUT outputs against the model every cycle
  always @(negedge clk) begin : cmp
    int w;
    logic [N-1:0] eg;
    if (rst) begin
      chk("rst req_ready", req_ready, 0);
      chk("rst ctl", {rsp_valid, rsp_error, rsp_timeout, busy, core_start}, 0);
      chk("rst rsp_id_y", {rsp_id, rsp_y}, 0);
      chk("rst core_ab", {core_a, core_b}, 0);
      m_active = 0; m_ptr = 0; acc_mask = '0; first_valid = -1;
    end else begin
      acc_mask = '0;
      if (!m_active) begin
        w = pick(req_valid, m_ptr);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("req_ready", req_ready, eg);
        chk("idle busy", busy, 0);
        chk("idle core_start", core_start, 0);
        chk("idle rsp_valid", rsp_valid, 0);
        acc_mask = req_ready;
        if (req_ready != 0 && acc_cnt < 1024) begin
          for (int i = N - 1; i >= 0; i--) if (req_ready[i]) a_id[acc_cnt] = i;
          a_cyc[acc_cnt] = cyc;
          acc_cnt++;
        end
        if (w >= 0) begin
          m_active = 1; m_acc = cyc; m_id = w;
          m_a = req_a[w*W +: W]; m_b = req_b[w*W +: W];
          m_k = (force_k >= 0) ? force_k : rand_k();
          m_to = (m_k > TO);
          m_rsp_start = cyc + 1 + (m_to ? TO : m_k) + 1;
          m_err = m_to || m_a == 0 || m_b == 0;
          m_y = m_to ? '0 : core_y_of(m_a, m_b);
        end
      end else begin
        chk("busy req_ready", req_ready, 0);
        chk("busy", busy, 1);
        chk("core_start", core_start, (cyc == m_acc + 1));
        if (cyc > m_acc && cyc < m_rsp_start) chk("core_ab", {core_a, core_b}, {m_a, m_b});
        chk("rsp_valid", rsp_valid, (cyc >= m_rsp_start));
        if (cyc >= m_rsp_start) begin
          if (rsp_valid && first_valid < 0) first_valid = cyc;
          chk("rsp_id", rsp_id, m_id);
          chk("rsp_y", rsp_y, m_y);
          chk("rsp_error", rsp_error, m_err);
          chk("rsp_timeout", rsp_timeout, m_to);
          if (rsp_ready) begin
            if (rsp_cnt < 1024) begin
              r_id[rsp_cnt] = rsp_id; r_y[rsp_cnt] = rsp_y; r_err[rsp_cnt] = rsp_error;
              r_to[rsp_cnt] = rsp_timeout; r_first[rsp_cnt] = first_valid;
              r_start[rsp_cnt] = last_start; r_hs[rsp_cnt] = cyc;
            end
            rsp_cnt++;
            m_active = 0; m_ptr = (m_id + 1) % N; first_valid = -1;
          end
        end
      end
      if (core_start) begin
        start_cnt++; last_start = cyc;
        done_at = cyc + m_k; st_a = core_a; st_b = core_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1; cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        if (rearm_en) begin aq[i] = W'($urandom_range(1, 255)); bq[i] = W'($urandom_range(1, 255)); end
        else vq[i] = 1'b0;
      end else if (rand_en && !vq[i] && $urandom_range(0, 3) == 0) begin
        vq[i] = 1'b1;
        aq[i] = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
        bq[i] = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      end
    end
    core_done  = (cyc == done_at);
    core_y     = core_y_of(st_a, st_b);
    core_error = (st_a == 0 || st_b == 0);
    if (!core_done && spur_en && (!m_active || cyc >= m_rsp_start) && $urandom_range(0, 7) == 0) begin
      core_done = 1'b1; core_y = W'($urandom); core_error = 1'($urandom);
    end
    rsp_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) begin
      req_valid[i] = vq[i];
      req_a[i*W +: W] = aq[i];
      req_b[i*W +: W] = bq[i];
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    vq[i] = 1'b1; aq[i] = W'(a); bq[i] = W'(b);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int b;
    b = 0;
    while (rsp_cnt < n && b < budget) begin tick(); b++; end
    chk("wait rsp", (rsp_cnt >= n), 1);
  endtask

  initial begin : main
    int b, sc, rc, base;
    for (int i = 0; i < N; i++) begin aq[i] = '0; bq[i] = '0; end
    #2 rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    // single request
    set_req(0, 6, 21);
    wait_rsp(1, 100);
    chk("t1 id", r_id[0], 0);
    chk("t1 y", r_y[0], 3);
    chk("t1 err", r_err[0], 0);
    chk("t1 starts", start_cnt, 1);
    chk("t1 start lat", r_start[0] - a_cyc[0], 1);
    chk("t1 rsp lat", r_first[0] - r_start[0], 4);

    // two simultaneous requests, then pointer check
    set_req(1, 5, 15); set_req(3, 17, 51);
    wait_rsp(3, 200);
    chk("t2 first id", r_id[1], 1);
    chk("t2 first y", r_y[1], 5);
    chk("t2 second id", r_id[2], 3);
    chk("t2 second y", r_y[2], 17);
    set_req(0, 4, 6); set_req(2, 9, 12);
    wait_rsp(5, 200);
    chk("t2 ptr wrap id", r_id[3], 0);
    chk("t2 ptr wrap y", r_y[3], 2);
    chk("t2 next id", r_id[4], 2);
    chk("t2 next y", r_y[4], 3);

    // zero operand: core error forwarded
    set_req(2, 0, 15);
    wait_rsp(6, 100);
    chk("t3 id", r_id[5], 2);
    chk("t3 err", r_err[5], 1);
    chk("t3 to", r_to[5], 0);
    chk("t3 y", r_y[5], 238);

    // core never answers
    force_k = 1000;
    set_req(1, 8, 12);
    wait_rsp(7, 200);
    chk("t4 err", r_err[6], 1);
    chk("t4 to", r_to[6], 1);
    chk("t4 y", r_y[6], 0);
    chk("t4 wd lat", r_first[6] - r_start[6], 21);
    force_k = 2;

    // response back-pressure, pending request accepted right after
    rdy_mode = 0;
    set_req(0, 10, 4);
    b = 0;
    while (first_valid < 0 && b < 100) begin tick(); b++; end
    chk("t5 rsp seen", (first_valid >= 0), 1);
    set_req(3, 21, 14);
    repeat (3) tick();
    rdy_mode = 1;
    wait_rsp(8, 50);
    b = 0;
    while (acc_cnt < 9 && b < 50) begin tick(); b++; end
    chk("t5 hold", r_hs[7] - r_first[7], 5);
    chk("t5 id", r_id[7], 0);
    chk("t5 y", r_y[7], 2);
    chk("t5 next id", a_id[8], 3);
    chk("t5 reaccept", a_cyc[8] - r_hs[7], 1);
    wait_rsp(9, 100);
    chk("t5 y2", r_y[8], 7);

    // reset while WAITing; late core_done must be ignored
    force_k = 8;
    sc = start_cnt;
    set_req(1, 9, 3);
    b = 0;
    while (start_cnt == sc && b < 50) begin tick(); b++; end
    chk("t6 started", (start_cnt > sc), 1);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("t6 rst busy", busy, 0);
    chk("t6 rst rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_id, rsp_y}, 0);
    chk("t6 rst core", {core_start, core_a, core_b}, 0);
    chk("t6 rst req_ready", req_ready, 0);
    rc = rsp_cnt;
    tick(); tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("t6 no rsp", rsp_cnt, rc);
    chk("t6 idle", busy, 0);

    // fairness with everyone requesting
    force_k = 1;
    rearm_en = 1;
    for (int i = 0; i < N; i++) set_req(i, 12 + i, 18);
    base = acc_cnt;
    b = 0;
    while (acc_cnt < base + 8 && b < 400) begin tick(); b++; end
    rearm_en = 0;
    chk("t7 accepts", (acc_cnt >= base + 8), 1);
    for (int k = 0; k < 8; k++) chk("t7 order", a_id[base + k], k % N);
    b = 0;
    while ((vq != 0 || m_active) && b < 400) begin tick(); b++; end
    chk("t7 drain", (vq == 0 && !m_active), 1);

    // randomized traffic
    force_k = -1; rand_en = 1; spur_en = 1; rdy_mode = 2;
    repeat (3000) tick();
    rand_en = 0; spur_en = 0; rdy_mode = 1;
    b = 0;
    while ((vq != 0 || m_active) && b < 2000) begin tick(); b++; end
    chk("final drain", (vq == 0 && !m_active), 1);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
